// File: rtl/pixel_frame_buffer_if.sv
// Host-write / pixeldriver-read bundle for the double-buffered frame store.
// The store itself takes the slave side; the host/driver side takes master.
interface pixel_frame_buffer_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              frame_pulse;
    logic              swap_done;
    logic              addr_err;
    logic [15:0]       swap_count;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, frame_pulse,
        input  wr_ready, rd_data, rd_valid, swap_done, addr_err, swap_count
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, frame_pulse,
        output wr_ready, rd_data, rd_valid, swap_done, addr_err, swap_count
    );
endinterface

// File: rtl/pixel_frame_buffer.sv
// Double-buffered grayscale frame store feeding pixeldriver. The host fills the
// back bank; banks swap only on pixeldriver's end-of-frame strobe.
module pixel_frame_buffer #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 192,
    parameter int ADDR_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    pixel_frame_buffer_if.slave  bus
);
    typedef enum logic {FILL, PENDING} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    state_t            state_q, state_d;
    logic              front_sel_q, front_sel_d;
    logic              wr_ready_q, wr_ready_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              swap_done_q, swap_done_d;
    logic              addr_err_q, addr_err_d;
    logic [15:0]       swap_count_q, swap_count_d;
    logic              mem_we;
    logic              wr_in_range;
    logic              rd_in_range;

    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_C;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_C;

    always_comb begin
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        swap_count_d = swap_count_q;
        swap_done_d  = 1'b0;
        addr_err_d   = addr_err_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = bus.rd_en;
        mem_we       = 1'b0;

        case (state_q)
            FILL: begin
                // wr_ready_q gates acceptance so nothing lands in the cycle right after reset
                if (bus.wr_valid && wr_ready_q) begin
                    if (wr_in_range) begin
                        mem_we = 1'b1;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    if (bus.wr_last) begin
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                if (bus.frame_pulse) begin
                    front_sel_d  = ~front_sel_q;
                    swap_count_d = swap_count_q + 16'd1;
                    swap_done_d  = 1'b1;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        wr_ready_d = (state_d == FILL);

        // Reads follow the post-swap bank so a read coinciding with the swap sees the new frame
        if (bus.rd_en) begin
            if (!rd_in_range) begin
                rd_data_d  = '0;
                addr_err_d = 1'b1;
            end else if (front_sel_d) begin
                rd_data_d = bank1[bus.rd_addr];
            end else begin
                rd_data_d = bank0[bus.rd_addr];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            front_sel_q  <= 1'b0;
            wr_ready_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            swap_done_q  <= 1'b0;
            addr_err_q   <= 1'b0;
            swap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            front_sel_q  <= front_sel_d;
            wr_ready_q   <= wr_ready_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            swap_done_q  <= swap_done_d;
            addr_err_q   <= addr_err_d;
            swap_count_q <= swap_count_d;
        end
    end

    // Frame storage is deliberately unreset; the back bank is the one not shown
    always_ff @(posedge clock) begin
        if (mem_we) begin
            if (front_sel_q) begin
                bank0[bus.wr_addr] <= bus.wr_data;
            end else begin
                bank1[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.wr_ready   = wr_ready_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.swap_done  = swap_done_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.swap_count = swap_count_q;
endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer: frame fill/swap, read latency,
// same-cycle commit/pulse, address errors, mid-frame reset and counter wrap.
module tb_pixel_frame_buffer;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 192;
    localparam int ADDR_W = 8;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    pixel_frame_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pixel_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_last = 1'b0;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.frame_pulse = 1'b0;
    endtask

    // mode 0: data = addr, mode 1: data = 0xFFF - addr
    function automatic logic [DATA_W-1:0] pat(input int mode, input int a);
        logic [DATA_W-1:0] v;
        v = (mode == 0) ? DATA_W'(a) : DATA_W'(12'hFFF - a);
        return v;
    endfunction

    task automatic write_frame(input int mode);
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = ADDR_W'(i);
            bus.wr_data = pat(mode, i); bus.wr_last = (i == DEPTH - 1);
            tick();
        end
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
        n_cmp++;
        if (bus.wr_ready !== 1'b0) begin
            $display("FAIL wr_ready_after_last got %b want 0", bus.wr_ready); n_bad++;
        end
    endtask

    task automatic read_frame(input int mode, input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(i);
            tick();
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== pat(mode, i)) begin
                $display("FAIL %s[%0d] got vld=%b data=%h want vld=1 data=%h",
                         tag, i, bus.rd_valid, bus.rd_data, pat(mode, i));
                n_bad++;
            end
        end
        bus.rd_en = 1'b0;
        tick();
        n_cmp++;
        if (bus.rd_valid !== 1'b0) begin
            $display("FAIL %s_vld_drop got %b want 0", tag, bus.rd_valid); n_bad++;
        end
    endtask

    task automatic read_one(input int a, input logic [DATA_W-1:0] exp, input string tag);
        bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(a);
        tick();
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
            $display("FAIL %s got vld=%b data=%h want vld=1 data=%h",
                     tag, bus.rd_valid, bus.rd_data, exp);
            n_bad++;
        end
    endtask

    task automatic pulse_swap(input logic exp_done, input logic [15:0] exp_cnt, input string tag);
        bus.frame_pulse = 1'b1;
        tick();
        bus.frame_pulse = 1'b0;
        n_cmp++;
        if (bus.swap_done !== exp_done || bus.swap_count !== exp_cnt) begin
            $display("FAIL %s got done=%b cnt=%h want done=%b cnt=%h",
                     tag, bus.swap_done, bus.swap_count, exp_done, exp_cnt);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (bus.swap_done !== 1'b0) begin
            $display("FAIL %s_done_width got %b want 0", tag, bus.swap_done); n_bad++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (bus.wr_ready !== 1'b0 || bus.rd_data !== '0 || bus.rd_valid !== 1'b0 ||
            bus.swap_done !== 1'b0 || bus.addr_err !== 1'b0 || bus.swap_count !== 16'h0) begin
            $display("FAIL %s got rdy=%b rd=%h vld=%b done=%b err=%b cnt=%h want all 0",
                     tag, bus.wr_ready, bus.rd_data, bus.rd_valid, bus.swap_done,
                     bus.addr_err, bus.swap_count);
            n_bad++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        check_reset_outputs("reset_values");
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.wr_ready !== 1'b0) begin
            $display("FAIL ready_before_edge got %b want 0", bus.wr_ready); n_bad++;
        end
        tick();
        n_cmp++;
        if (bus.wr_ready !== 1'b1) begin
            $display("FAIL ready_after_release got %b want 1", bus.wr_ready); n_bad++;
        end
    endtask

    task automatic test_frame1();
        write_frame(0);
        pulse_swap(1'b1, 16'd1, "swap1");
        n_cmp++;
        if (bus.wr_ready !== 1'b1) begin
            $display("FAIL ready_after_swap1 got %b want 1", bus.wr_ready); n_bad++;
        end
        read_frame(0, "frame1");
    endtask

    task automatic test_frame2_hold();
        write_frame(1);
        // A beat offered while waiting for the swap must not be taken
        bus.wr_valid = 1'b1; bus.wr_addr = '0; bus.wr_data = 12'h123;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.wr_ready !== 1'b0) begin
                $display("FAIL ready_pending[%0d] got %b want 0", i, bus.wr_ready); n_bad++;
            end
        end
        bus.wr_valid = 1'b0;
        read_frame(0, "frame1_still");
        // read issued on the swap edge sees the new bank
        bus.rd_en = 1'b1; bus.rd_addr = 8'd7;
        pulse_swap(1'b1, 16'd2, "swap2");
        n_cmp++;
        if (bus.rd_data !== 12'hFF8) begin
            $display("FAIL read_on_swap got %h want ff8", bus.rd_data); n_bad++;
        end
        bus.rd_en = 1'b0;
        read_frame(1, "frame2");
    endtask

    task automatic test_same_cycle();
        bus.wr_valid = 1'b1; bus.wr_addr = '0; bus.wr_data = 12'hAAA; bus.wr_last = 1'b1;
        bus.frame_pulse = 1'b1;
        tick();
        idle_inputs();
        n_cmp++;
        if (bus.swap_done !== 1'b0 || bus.swap_count !== 16'd2 || bus.wr_ready !== 1'b0) begin
            $display("FAIL same_cycle got done=%b cnt=%h rdy=%b want 0/0002/0",
                     bus.swap_done, bus.swap_count, bus.wr_ready);
            n_bad++;
        end
        read_one(0, 12'hFFF, "same_cycle_front");
        pulse_swap(1'b1, 16'd3, "swap3");
        read_one(0, 12'hAAA, "swap3_new");
        read_one(1, 12'h001, "swap3_kept");
        // pulse while filling does nothing
        pulse_swap(1'b0, 16'd3, "fill_pulse");
        read_one(0, 12'hAAA, "fill_pulse_front");
    endtask

    task automatic test_addr_err();
        n_cmp++;
        if (bus.addr_err !== 1'b0) begin
            $display("FAIL err_clear got %b want 0", bus.addr_err); n_bad++;
        end
        bus.wr_valid = 1'b1; bus.wr_addr = 8'd200; bus.wr_data = 12'h555;
        tick();
        n_cmp++;
        if (bus.addr_err !== 1'b1) begin
            $display("FAIL err_write got %b want 1", bus.addr_err); n_bad++;
        end
        bus.wr_addr = 8'd201; bus.wr_last = 1'b1;
        tick();
        idle_inputs();
        n_cmp++;
        if (bus.wr_ready !== 1'b0) begin
            $display("FAIL oor_last_commit got rdy=%b want 0", bus.wr_ready); n_bad++;
        end
        read_one(250, 12'h000, "oor_read");
        pulse_swap(1'b1, 16'd4, "swap4");
        read_frame(1, "bank_untouched");
        n_cmp++;
        if (bus.addr_err !== 1'b1) begin
            $display("FAIL err_sticky got %b want 1", bus.addr_err); n_bad++;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH / 2; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = ADDR_W'(i);
            bus.wr_data = 12'h111; bus.wr_last = (i == DEPTH / 2 - 1);
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset_async");
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (bus.wr_ready !== 1'b1) begin
            $display("FAIL mid_reset_fill got %b want 1", bus.wr_ready); n_bad++;
        end
        pulse_swap(1'b0, 16'd0, "post_reset_pulse");
        read_one(10, 12'hFF5, "post_reset_front");
        read_one(250, 12'h000, "oor_read_only");
        n_cmp++;
        if (bus.addr_err !== 1'b1) begin
            $display("FAIL err_from_read got %b want 1", bus.addr_err); n_bad++;
        end
    endtask

    task automatic test_wrap();
        force dut.swap_count_q = 16'hFFFE;
        #1;
        release dut.swap_count_q;
        for (int k = 0; k < 2; k++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = '0; bus.wr_data = 12'h0; bus.wr_last = 1'b1;
            tick();
            idle_inputs();
            pulse_swap(1'b1, (k == 0) ? 16'hFFFF : 16'h0000, (k == 0) ? "swap_ffff" : "swap_wrap");
        end
    endtask

    initial begin
        test_reset();
        test_frame1();
        test_frame2_hold();
        test_same_cycle();
        test_addr_err();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
